input_bridge_param: RTL and testbench
=====================================

// Module: input_bridge_param
// PURPOSE
//  Parametrised host-to-core input bridge. Demuxes one host write stream into NUM_CH per-channel FIFOs.
//  Each channel drains one word per core credit (single-bit credit, set on reset).
//  Extends the fixed 20-channel bridge with: configurable width/depth/channel count, atomic broadcast writes,
//  sticky out-of-range port error, and per-channel occupancy output. Sits between host interface and overlay core.
// PARAMETERS
//  NUM_CH   20  number of core input channels (>=2)
//  DATA_W   33  host word width (data + tag bit)
//  DEPTH    4   entries per channel FIFO, power of 2, >=2
//  PORT_W   5   port index width, >= clog2(NUM_CH)
//  AW       2   log2(DEPTH)
// PORTS
//  clk      in   1                    clock, all state on posedge
//  rst      in   1                    synchronous, active-high reset
//  conf_en  in   1                    configuration phase; blocks all dequeues while high
//  d_in     in   DATA_W               host write data
//  port     in   PORT_W               target channel index
//  bcast    in   1                    write to all channels (port ignored)
//  wr_en    in   1                    host write request
//  busy     out  1                    write refused this cycle (combinational)
//  err_clr  in   1                    clears err_port
//  err_port out  1                    sticky: write attempted to port >= NUM_CH
//  c_in     in   NUM_CH               per-channel credit pulse from core
//  d_out    out  NUM_CH*(DATA_W+2)    ch i slice = {data[DATA_W-1:0], 1'b1, valid}
//  level    out  NUM_CH*(AW+1)        ch i FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (rst=1 at edge): all FIFOs empty, level=0, all valid=0, output data=0, credit=1 on every ch, err_port=0.
//  Target set T: bcast ? all ones : (port<NUM_CH ? onehot(port) : 0).
//  busy = wr_en & |(T & full); full = (count==DEPTH). Full is sampled pre-edge; a same-cycle pop does not clear busy.
//  Enqueue: wr_en & ~busy pushes d_in into every ch in T at the same edge. Broadcast is atomic:
//   one full ch blocks all chs. Host holds d_in/port/bcast/wr_en until busy=0.
//  Out-of-range (wr_en & ~bcast & port>=NUM_CH): no enqueue, busy=0, err_port=1 next edge.
//   err_clr clears it; if set and clear coincide, set wins.
//  Pop condition per ch i: credit[i] & ~conf_en & ~empty[i].
//   On pop: valid<=1, out data<=head, rd ptr++, credit<=c_in[i].
//   Otherwise: valid<=0, data holds last value, credit<=credit|c_in[i].
//  Credits do not accumulate beyond 1. Each valid=1 cycle delivers exactly one word.
//  Simultaneous enq+pop on one ch: count unchanged, both occur. Pop of last entry + enq: count stays 1.
//  Latency: write accepted at edge E -> earliest valid=1 in the cycle after edge E+1 (2 cycles).
//  Back-to-back: credit held high by c_in each cycle -> one word per cycle, no bubbles.
//  Pointers wrap modulo DEPTH. Count is AW+1 bits, never exceeds DEPTH.
//  Reset mid-operation discards all FIFO contents and pending output. Credits return to 1.
//  Bit 1 of each d_out slice is constant 1.
// TESTING
//  1 Reset, write port=3 d=0x1A5, c_in=0 -> d_out[3] valid pulse 2 cycles later, data 0x1A5; no further pulse w/o c_in.
//  2 DEPTH=4, ch 5: 5 writes, no credit consumed after 1st pop -> writes 2..5 fill; 6th write busy=1; level[5]=4.
//  3 bcast=1 with ch 7 full -> busy=1, no ch level changes; free ch 7 via c_in -> broadcast lands in all NUM_CH chs.
//  4 port=NUM_CH+2 write -> err_port=1 next cycle, no level change, busy=0; err_clr -> err_port=0.
//  5 conf_en=1 with ch 0 nonempty + credit -> no valid. Drop conf_en -> valid next cycle. c_in every cycle -> 1 word/cycle in order.
//  6 Random writes/credits with rst asserted mid-stream -> all levels 0, valid=0, credits=1. Scoreboard order per ch.

Source files
------------

// File: rtl/input_bridge_param.sv
// Host-to-core input bridge: demuxes one host write stream into NUM_CH credit-drained FIFOs,
// with atomic broadcast, sticky out-of-range port error and per-channel occupancy.
module input_bridge_param #(
  parameter int NUM_CH = 20,
  parameter int DATA_W = 33,
  parameter int DEPTH  = 4,
  parameter int PORT_W = 5,
  parameter int AW     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           conf_en,
  input  logic [DATA_W-1:0]              d_in,
  input  logic [PORT_W-1:0]              port,
  input  logic                           bcast,
  input  logic                           wr_en,
  output logic                           busy,
  input  logic                           err_clr,
  output logic                           err_port,
  input  logic [NUM_CH-1:0]              c_in,
  output logic [NUM_CH*(DATA_W+2)-1:0]   d_out,
  output logic [NUM_CH*(AW+1)-1:0]       level
);

  localparam int SW = DATA_W + 2;

  logic [DATA_W-1:0] mem    [NUM_CH][DEPTH];
  logic [AW-1:0]     wr_ptr [NUM_CH];
  logic [AW-1:0]     rd_ptr [NUM_CH];
  logic [AW:0]       count  [NUM_CH];
  logic [DATA_W-1:0] data_q [NUM_CH];
  logic [NUM_CH-1:0] valid_q, credit_q;
  logic [NUM_CH-1:0] full, empty, tgt, push, pop;
  logic              port_ok, err_q;

  always_comb begin
    port_ok = 32'(port) < NUM_CH;
    tgt     = '0;
    if (bcast)        tgt = '1;
    else if (port_ok) tgt = NUM_CH'(1) << port;
    for (int i = 0; i < NUM_CH; i++) begin
      full[i]  = (count[i] == (AW+1)'(DEPTH));
      empty[i] = (count[i] == '0);
    end
    // Full is taken before the edge, so a pop in the same cycle does not release busy.
    busy = wr_en & |(tgt & full);
    push = (wr_en & ~busy) ? tgt : '0;
    pop  = credit_q & ~empty & {NUM_CH{~conf_en}};
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= d_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
        data_q[i] <= '0;
      end
      valid_q  <= '0;
      credit_q <= '1;
      err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i]) begin
          rd_ptr[i]   <= rd_ptr[i] + 1'b1;
          data_q[i]   <= mem[i][rd_ptr[i]];
          valid_q[i]  <= 1'b1;
          credit_q[i] <= c_in[i];
        end else begin
          valid_q[i]  <= 1'b0;
          credit_q[i] <= credit_q[i] | c_in[i];
        end
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
      // A new error beats a coincident clear.
      if (wr_en & ~bcast & ~port_ok) err_q <= 1'b1;
      else if (err_clr)              err_q <= 1'b0;
    end
  end

  always_comb begin
    d_out = '0;
    level = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      d_out[i*SW +: SW]         = {data_q[i], 1'b1, valid_q[i]};
      level[i*(AW+1) +: (AW+1)] = count[i];
    end
    err_port = err_q;
  end

endmodule

// File: tb/tb_input_bridge_param.sv
// Bench for input_bridge_param: directed scenarios then randomized traffic, all checked
// against a queue-based reference model of the bridge.
module tb_input_bridge_param;

  localparam int NUM_CH = 20;
  localparam int DATA_W = 33;
  localparam int DEPTH  = 4;
  localparam int PORT_W = 5;
  localparam int AW     = 2;
  localparam int SW     = DATA_W + 2;
  localparam int DW     = NUM_CH * SW;
  localparam int LW     = NUM_CH * (AW + 1);

  logic              clk = 1'b0;
  logic              rst, conf_en, bcast, wr_en, err_clr;
  logic              busy, err_port;
  logic [DATA_W-1:0] d_in;
  logic [PORT_W-1:0] port;
  logic [NUM_CH-1:0] c_in;
  logic [DW-1:0]     d_out;
  logic [LW-1:0]     level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  input_bridge_param #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .PORT_W(PORT_W), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .conf_en(conf_en), .d_in(d_in), .port(port),
    .bcast(bcast), .wr_en(wr_en), .busy(busy), .err_clr(err_clr),
    .err_port(err_port), .c_in(c_in), .d_out(d_out), .level(level)
  );

  // Reference model: one word queue per channel plus credit/output registers.
  logic [DATA_W-1:0] mq   [NUM_CH][$];
  bit                mcred[NUM_CH];
  bit                mval [NUM_CH];
  logic [DATA_W-1:0] mdat [NUM_CH];
  bit                merr;

  function automatic bit in_target(int i);
    return bcast || (int'(port) == i);
  endfunction

  function automatic bit m_busy();
    if (!wr_en) return 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (in_target(i) && mq[i].size() == DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] exp_dout();
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CH; i++) v[i*SW +: SW] = {mdat[i], 1'b1, mval[i]};
    return v;
  endfunction

  function automatic logic [LW-1:0] exp_level();
    logic [LW-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CH; i++) v[i*(AW+1) +: (AW+1)] = (AW+1)'(mq[i].size());
    return v;
  endfunction

  task automatic model_edge();
    bit b;
    b = m_busy();
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mq[i].delete();
        mcred[i] = 1'b1;
        mval[i]  = 1'b0;
        mdat[i]  = '0;
      end
      merr = 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (mcred[i] && !conf_en && mq[i].size() > 0) begin
          mdat[i]  = mq[i].pop_front();
          mval[i]  = 1'b1;
          mcred[i] = c_in[i];
        end else begin
          mval[i]  = 1'b0;
          mcred[i] = mcred[i] | c_in[i];
        end
        if (wr_en && !b && in_target(i)) mq[i].push_back(d_in);
      end
      if (wr_en && !bcast && int'(port) >= NUM_CH) merr = 1'b1;
      else if (err_clr)                            merr = 1'b0;
    end
  endtask

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    #1;
    chk("busy", DW'(busy), DW'(m_busy()));
    @(posedge clk);
    model_edge();
    #1;
    chk("d_out", d_out, exp_dout());
    chk("level", DW'(level), DW'(exp_level()));
    chk("err_port", DW'(err_port), DW'(merr));
  endtask

  task automatic wr(int p, logic [DATA_W-1:0] d, bit bc);
    int k;
    port  = PORT_W'(p);
    d_in  = d;
    bcast = bc;
    wr_en = 1'b1;
    k = 0;
    while (m_busy() && k < 20) begin
      cycle();
      k++;
    end
    chk("wr_timeout", DW'(k < 20), DW'(1));
    cycle();
    wr_en = 1'b0;
    bcast = 1'b0;
  endtask

  task automatic drain();
    c_in = '1;
    repeat (8) cycle();
    c_in = '0;
  endtask

  function automatic logic [DATA_W-1:0] rnd_word();
    return DATA_W'({$urandom(), $urandom()});
  endfunction

  logic [DATA_W-1:0] words [3];

  initial begin
    rst = 1'b1; conf_en = 1'b0; bcast = 1'b0; wr_en = 1'b0; err_clr = 1'b0;
    d_in = '0; port = '0; c_in = '0;
    cycle();
    chk("reset_level", DW'(level), DW'(0));
    chk("reset_dout", d_out, {NUM_CH{ {DATA_W'(0), 1'b1, 1'b0} }});
    rst = 1'b0;
    cycle();

    // Single write to ch 3: valid pulse two cycles after the accepting edge, only once.
    wr(3, DATA_W'(33'h1A5), 1'b0);
    cycle();
    chk("t1_valid", DW'(d_out[3*SW]), DW'(1));
    chk("t1_data", DW'(d_out[3*SW+2 +: DATA_W]), DW'(33'h1A5));
    cycle();
    chk("t1_no_repeat", DW'(d_out[3*SW]), DW'(0));
    repeat (2) cycle();

    // Fill ch 5: first write is drained by the reset credit, the next four fill it.
    for (int n = 0; n < 5; n++) wr(5, rnd_word(), 1'b0);
    chk("t2_level", DW'(level[5*(AW+1) +: (AW+1)]), DW'(4));
    port = PORT_W'(5); wr_en = 1'b1;
    #1;
    chk("t2_busy", DW'(busy), DW'(1));
    cycle();
    wr_en = 1'b0;
    drain();

    // Broadcast blocked by full ch 7 until one credit frees a slot.
    for (int n = 0; n < 5; n++) wr(7, rnd_word(), 1'b0);
    d_in = rnd_word(); bcast = 1'b1; wr_en = 1'b1;
    repeat (3) cycle();
    #1;
    chk("t3_busy", DW'(busy), DW'(1));
    c_in[7] = 1'b1;
    cycle();
    c_in = '0;
    wr(0, d_in, 1'b1);
    chk("t3_level7", DW'(level[7*(AW+1) +: (AW+1)]), DW'(4));
    chk("t3_level0", DW'(level[0 +: (AW+1)]), DW'(1));
    chk("t3_level19", DW'(level[19*(AW+1) +: (AW+1)]), DW'(1));
    drain();

    // Out-of-range port sets the sticky error; clear; then set beats clear.
    port = PORT_W'(NUM_CH + 2); wr_en = 1'b1; d_in = rnd_word();
    cycle();
    wr_en = 1'b0;
    chk("t4_err_set", DW'(err_port), DW'(1));
    chk("t4_level", DW'(level), DW'(0));
    err_clr = 1'b1;
    cycle();
    chk("t4_err_clr", DW'(err_port), DW'(0));
    port = PORT_W'(31); wr_en = 1'b1;
    cycle();
    chk("t4_set_wins", DW'(err_port), DW'(1));
    wr_en = 1'b0;
    cycle();
    err_clr = 1'b0;

    // conf_en holds off dequeues; after release, continuous credit gives one word per cycle.
    drain();
    conf_en = 1'b1;
    for (int n = 0; n < 3; n++) begin
      words[n] = rnd_word();
      wr(0, words[n], 1'b0);
    end
    repeat (2) cycle();
    chk("t5_blocked", DW'(d_out[0]), DW'(0));
    chk("t5_level", DW'(level[0 +: (AW+1)]), DW'(3));
    conf_en = 1'b0;
    c_in[0] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cycle();
      chk("t5_valid", DW'(d_out[0]), DW'(1));
      chk("t5_order", DW'(d_out[2 +: DATA_W]), DW'(words[n]));
    end
    cycle();
    chk("t5_empty", DW'(d_out[0]), DW'(0));
    c_in = '0;

    // Randomized traffic with a reset in the middle.
    for (int n = 0; n < 400; n++) begin
      if (!(wr_en && m_busy())) begin
        wr_en   = ($urandom_range(0, 2) != 0);
        port    = PORT_W'($urandom_range(0, NUM_CH + 3));
        bcast   = ($urandom_range(0, 15) == 0);
        d_in    = rnd_word();
        conf_en = ($urandom_range(0, 15) == 0);
        err_clr = ($urandom_range(0, 7) == 0);
      end
      c_in = NUM_CH'($urandom()) & NUM_CH'($urandom());
      rst  = (n == 200 || n == 201);
      cycle();
      if (n == 201) begin
        chk("t6_rst_level", DW'(level), DW'(0));
        chk("t6_rst_dout", d_out, {NUM_CH{ {DATA_W'(0), 1'b1, 1'b0} }});
        chk("t6_rst_err", DW'(err_port), DW'(0));
      end
    end
    rst = 1'b0; wr_en = 1'b0; conf_en = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
